// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer with a small hardware return-address stack.
// On each step pulse it advances the PC: sequential (pc+1), jump,
// call (push pc+1 and jump) or return (pop into pc). Stack misuse or a
// simultaneous call/ret drives a sticky fault that only reset clears.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   step       - advance the PC this cycle
//   inc_n      - 1 = sequential, 0 = load jmp_addr
//   jmp_addr   - jump / call target
//   call       - push pc+1 and load jmp_addr
//   ret        - pop the stack top into pc
//   pc         - current program counter (registered)
//   sp         - number of valid stack entries (registered)
//   fault      - sticky fault flag (registered)
//   fault_code - 00 none, 01 overflow, 10 underflow, 11 call&ret (registered)
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           step,
  input  logic                           inc_n,
  input  logic [ADDR_W-1:0]              jmp_addr,
  input  logic                           call,
  input  logic                           ret,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           fault,
  output logic [1:0]                     fault_code
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Next sequential address; wraps modulo 2^ADDR_W with no flag.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  state_t             state_r, state_nxt_s;
  logic [ADDR_W-1:0]  pc_r, pc_nxt_s;
  logic [SP_W-1:0]    sp_r, sp_nxt_s;
  logic               fault_r, fault_nxt_s;
  logic [1:0]         code_r, code_nxt_s;
  logic [1:0]         err_code_s;
  logic               act_s;
  logic               push_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  stack_r [STACK_DEPTH];

  // The low index bits give the push slot; when sp==STACK_DEPTH they are 0
  // and the decrement still lands on the top entry.
  assign wr_idx_s = sp_r[IDX_W-1:0];
  assign rd_idx_s = sp_r[IDX_W-1:0] - IDX_W'(1);
  assign pc_inc_s = next_addr(pc_r);

  // State register and registered outputs, reset has top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_VEC;
      sp_r    <= {SP_W{1'b0}};
      fault_r <= 1'b0;
      code_r  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      sp_r    <= sp_nxt_s;
      fault_r <= fault_nxt_s;
      code_r  <= code_nxt_s;
    end
  end

  // Return-address storage; contents above sp are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      stack_r[wr_idx_s] <= pc_inc_s;
    end
  end

  // Next-state logic: classify the requested action and detect misuse.
  always_comb begin
    act_s       = 1'b0;
    err_code_s  = 2'b00;
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        act_s = step;
        if (call && ret) begin
          err_code_s = 2'b11;
        end else if (ret && (sp_r == {SP_W{1'b0}})) begin
          err_code_s = 2'b10;
        end else if (call && (sp_r == SP_W'(STACK_DEPTH))) begin
          err_code_s = 2'b01;
        end else begin
          err_code_s = 2'b00;
        end
        if (step && (err_code_s != 2'b00)) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // Output / datapath logic: next pc, sp, fault and stack push strobe.
  always_comb begin
    pc_nxt_s    = pc_r;
    sp_nxt_s    = sp_r;
    fault_nxt_s = fault_r;
    code_nxt_s  = code_r;
    push_s      = 1'b0;
    if (act_s) begin
      if (err_code_s != 2'b00) begin
        fault_nxt_s = 1'b1;
        code_nxt_s  = err_code_s;
      end else if (ret) begin
        pc_nxt_s = stack_r[rd_idx_s];
        sp_nxt_s = sp_r - SP_W'(1);
      end else if (call) begin
        push_s   = 1'b1;
        pc_nxt_s = jmp_addr;
        sp_nxt_s = sp_r + SP_W'(1);
      end else if (!inc_n) begin
        pc_nxt_s = jmp_addr;
      end else begin
        pc_nxt_s = pc_inc_s;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pc         = pc_r;
  assign sp         = sp_r;
  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic       inc_n;
  logic [7:0] jmp_addr;
  logic       call;
  logic       ret;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       fault;
  logic [1:0] fault_code;

  int total_cnt = 0;
  int bad_cnt   = 0;

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .inc_n      (inc_n),
    .jmp_addr   (jmp_addr),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .sp         (sp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output against its expected value.
  task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic [2:0] e_sp,
                         input logic e_fault, input logic [1:0] e_code);
    chk({tag, ".pc"},    32'(pc),         32'(e_pc));
    chk({tag, ".sp"},    32'(sp),         32'(e_sp));
    chk({tag, ".fault"}, 32'(fault),      32'(e_fault));
    chk({tag, ".code"},  32'(fault_code), 32'(e_code));
  endtask

  // Applies one cycle of inputs, then samples 1 time unit after the edge.
  task automatic cyc(input logic r_n, input logic st, input logic inc, input logic [7:0] ja,
                     input logic c, input logic r);
    rst_n    = r_n;
    step     = st;
    inc_n    = inc;
    jmp_addr = ja;
    call     = c;
    ret      = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; inc_n = 1'b1; jmp_addr = 8'h00; call = 1'b0; ret = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_all("reset", 8'h00, 3'd0, 1'b0, 2'b00);

    // Sequential stepping.
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); chk_all("seq1", 8'h01, 3'd0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); chk_all("seq2", 8'h02, 3'd0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); chk_all("seq3", 8'h03, 3'd0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); chk("seq5.pc", 32'(pc), 32'h05);

    // Jump, then an idle cycle with jump-looking inputs holds.
    cyc(1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0); chk("jmp.pc", 32'(pc), 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0); chk("idle.pc", 32'(pc), 32'h40);
    cyc(1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0); chk_all("idle_call", 8'h40, 3'd0, 1'b0, 2'b00);

    // Nested calls and returns; inc_n is irrelevant for call.
    cyc(1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0); chk_all("call1", 8'h80, 3'd1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b0); chk_all("call2", 8'hA0, 3'd2, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1); chk_all("ret1",  8'h81, 3'd1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1); chk_all("ret2",  8'h11, 3'd0, 1'b0, 2'b00);

    // Wrap on sequential step and on pushed return address.
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); chk_all("wrap_seq", 8'h00, 3'd0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0); chk_all("wrap_call", 8'h20, 3'd1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("wrap_ret",  8'h00, 3'd0, 1'b0, 2'b00);

    // Fill the stack, drain it in LIFO order.
    cyc(1'b1, 1'b1, 1'b1, 8'h50, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h90, 1'b1, 1'b0); chk_all("fill4", 8'h90, 3'd4, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("pop4", 8'h71, 3'd3, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("pop3", 8'h61, 3'd2, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("pop2", 8'h51, 3'd1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("pop1", 8'h01, 3'd0, 1'b0, 2'b00);

    // Overflow: pc=0x01, refill then a fifth call faults.
    cyc(1'b1, 1'b1, 1'b1, 8'h50, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h90, 1'b1, 1'b0); chk_all("refill", 8'h90, 3'd4, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b0); chk_all("ovf", 8'h90, 3'd4, 1'b1, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("ovf_ret", 8'h90, 3'd4, 1'b1, 2'b01);
    cyc(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0); chk_all("ovf_jmp", 8'h90, 3'd4, 1'b1, 2'b01);
    cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0); chk_all("ovf_rst", 8'h00, 3'd0, 1'b0, 2'b00);

    // Underflow.
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("udf", 8'h00, 3'd0, 1'b1, 2'b10);
    cyc(1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0); chk_all("udf_hold", 8'h00, 3'd0, 1'b1, 2'b10);

    // Illegal call&ret after reset (reset asserted with a ret pending).
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1); chk_all("udf_rst", 8'h00, 3'd0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0); chk_all("pre_ill", 8'h00, 3'd1, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1); chk_all("illegal", 8'h00, 3'd1, 1'b1, 2'b11);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0); chk_all("final_rst", 8'h00, 3'd0, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor core. It consumes the jump decision from the branch-select logic: a 1-bit flag where 1 means "fall through" and 0 means "take the jump". On each instruction step it produces the next PC, and it provides call/return via a small hardware return-address stack. It sits between control decode and the instruction memory address port, and holds a sticky fault state on stack misuse.

## Interface
Parameters:
- ADDR_W, 8, PC / address width in bits.
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- step  in  1  advance PC this cycle (one pulse per executed instruction).
- inc_n  in  1  branch-select flag: 1 = sequential (pc+1), 0 = load jmp_addr.
- jmp_addr  in  ADDR_W  jump/call target.
- call  in  1  unconditional call: push pc+1, load jmp_addr.
- ret  in  1  return: pop stack top into pc.
- pc  out  ADDR_W  current program counter (registered).
- sp  out  log2(STACK_DEPTH)+1  number of valid stack entries (0..STACK_DEPTH).
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 overflow, 10 underflow, 11 illegal (call & ret).

## Operation
- States: RUN, FAULT. Reset → RUN.
- In RUN, the action is evaluated only when step=1. When step=0, all state holds and call/ret/inc_n are ignored.
- Priority when step=1:
  1. call&ret both high → FAULT with code 11.
  2. ret:
     - sp=0 → FAULT with code 10.
     - Otherwise pc ← stack[sp-1] and sp ← sp-1.
  3. call:
     - sp=STACK_DEPTH → FAULT with code 01.
     - Otherwise stack[sp] ← pc+1, sp ← sp+1, and pc ← jmp_addr.
  4. inc_n=0 → pc ← jmp_addr.
  5. Otherwise pc ← pc+1.
- call and ret ignore inc_n.
- Arithmetic:
  - pc+1 is computed modulo 2^ADDR_W. pc=2^ADDR_W-1 wraps to 0, with no flag.
  - A pushed return address wraps the same way.
- Faulting step:
  - pc, sp and stack contents are unchanged.
  - fault ← 1 and fault_code is set. The state moves to FAULT.
- FAULT state:
  - All inputs except rst_n are ignored.
  - pc, sp, fault and fault_code hold.
  - Only reset exits.
- Stack is LIFO. Entries at index ≥ sp are don't-care and are never observable on outputs.
- Reset values:
  - pc=RESET_VEC, sp=0, fault=0, fault_code=00, state RUN.
  - Stack contents need not be cleared.
- Reset has priority over every other input in the same cycle, including mid-call or mid-ret and while in FAULT.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency 1: the action sampled at edge N appears on pc/sp/fault after edge N.
- Back-to-back steps are supported, one action per cycle at full rate (e.g. call followed immediately by ret returns correctly).
- A ret in the cycle immediately after a call returns the address pushed by that call.
- rst_n sampled low at an edge → reset values visible after that edge. The first step can be accepted at the first edge with rst_n=1.
- inc_n, jmp_addr, call and ret only need to be valid in cycles where step=1.

## Test plan
- Reset then 3 steps with inc_n=1, RESET_VEC=0 → pc 0,1,2,3; sp=0; fault=0.
- At pc=5: step, inc_n=0, jmp_addr=0x40 → pc=0x40 next cycle. Then step=0 with inc_n=0, jmp_addr=0x10 → pc stays 0x40.
- Nested calls:
  - From pc=0x10, call to 0x80, then at 0x80 call to 0xA0 → sp=2.
  - ret → pc=0x81, sp=1.
  - ret → pc=0x11, sp=0.
- Overflow: 4 calls fill the stack (sp=4), 5th call → fault=1, code 01, pc and sp unchanged. Further steps/rets are ignored. rst_n low one cycle → pc=0, sp=0, fault=0.
- Underflow and illegal:
  - ret with sp=0 → fault code 10.
  - After reset, step with call=ret=1 → fault code 11, pc unchanged.
- Wrap: at pc=0xFF, step inc_n=1 → pc=0x00. At pc=0xFF, call to 0x20 then ret → pc=0x00.
